// File: rtl/zet_bus_arbiter.sv
// Shares one Wishbone master port between the 8086 core and a DMA controller (HOLD/HLDA),
// splitting odd-address word accesses into two byte cycles. Optional ack timeout: ZET_ARB_TIMEOUT_EN.
module zet_bus_arbiter #(
    parameter int TMO_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] cpu_adr_i,
    input  logic [15:0] cpu_wdat_i,
    output logic [15:0] cpu_rdat_o,
    input  logic        cpu_byte_i,
    input  logic        cpu_mem_op_i,
    input  logic        cpu_m_io_i,
    input  logic        cpu_we_i,
    output logic        cpu_block_o,
    input  logic        dma_hreq_i,
    output logic        dma_hlda_o,
    input  logic [19:0] dma_adr_i,
    input  logic [15:0] dma_dat_i,
    input  logic [1:0]  dma_sel_i,
    input  logic        dma_we_i,
    input  logic        dma_stb_i,
    input  logic        dma_tga_i,
    output logic [18:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic [1:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_tga_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        wb_ack_dma_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, CPU1, CPU2, HOLD} state_t;

    state_t      state_reg, state_next;
    logic [19:0] adr_reg, adr_next;
    logic [1:0]  sel_reg, sel_next;
    logic [15:0] dat_reg, dat_next;
    logic [7:0]  hi_reg, hi_next;
    logic        we_reg, we_next;
    logic        tga_reg, tga_next;
    logic        byte_reg, byte_next;
    logic        odd_reg, odd_next;
    logic        stb_reg, stb_next;
    logic [15:0] rdat_reg, rdat_next;
    logic        done_reg, done_next;
    logic        token_reg, token_next;

    logic        hold;
    logic        tmo_hit;
    logic        cyc_ack;
    logic [15:0] bus_dat;
    logic [19:0] cpu_adr_eff;
    logic [19:0] adr_inc;
    logic        unused_bits;

    // IO space is 64K: upper address bits are forced to zero and increments wrap at 16 bits
    assign cpu_adr_eff = cpu_m_io_i ? {4'h0, cpu_adr_i[15:0]} : cpu_adr_i;
    assign adr_inc     = tga_reg ? {4'h0, adr_reg[15:0] + 16'd1} : adr_reg + 20'd1;

    assign cyc_ack = stb_reg & (wb_ack_i | tmo_hit);
    assign bus_dat = tmo_hit ? 16'hFFFF : wb_dat_i;

`ifdef ZET_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_reg;
    logic          err_reg;

    assign tmo_hit   = stb_reg & ~wb_ack_i & (tmo_cnt_reg == CW'(TMO_CYCLES - 1));
    assign bus_err_o = err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            err_reg <= tmo_hit;
            if (stb_reg && !wb_ack_i && !tmo_hit)
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            else
                tmo_cnt_reg <= '0;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            adr_reg   <= '0;
            sel_reg   <= '0;
            dat_reg   <= '0;
            hi_reg    <= '0;
            we_reg    <= 1'b0;
            tga_reg   <= 1'b0;
            byte_reg  <= 1'b0;
            odd_reg   <= 1'b0;
            stb_reg   <= 1'b0;
            rdat_reg  <= '0;
            done_reg  <= 1'b0;
            token_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            adr_reg   <= adr_next;
            sel_reg   <= sel_next;
            dat_reg   <= dat_next;
            hi_reg    <= hi_next;
            we_reg    <= we_next;
            tga_reg   <= tga_next;
            byte_reg  <= byte_next;
            odd_reg   <= odd_next;
            stb_reg   <= stb_next;
            rdat_reg  <= rdat_next;
            done_reg  <= done_next;
            token_reg <= token_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        adr_next   = adr_reg;
        sel_next   = sel_reg;
        dat_next   = dat_reg;
        hi_next    = hi_reg;
        we_next    = we_reg;
        tga_next   = tga_reg;
        byte_next  = byte_reg;
        odd_next   = odd_reg;
        stb_next   = stb_reg;
        rdat_next  = rdat_reg;
        token_next = token_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // The token gives a waiting CPU one access between back-to-back holds
                if (dma_hreq_i && !(token_reg && cpu_mem_op_i)) begin
                    state_next = HOLD;
                    token_next = 1'b0;
                end else if (cpu_mem_op_i && !done_reg) begin
                    state_next = CPU1;
                    stb_next   = 1'b1;
                    adr_next   = cpu_adr_eff;
                    we_next    = cpu_we_i;
                    tga_next   = cpu_m_io_i;
                    byte_next  = cpu_byte_i;
                    odd_next   = !cpu_byte_i && cpu_adr_eff[0];
                    hi_next    = cpu_wdat_i[15:8];
                    if (cpu_byte_i || cpu_adr_eff[0]) begin
                        sel_next = cpu_adr_eff[0] ? 2'b10 : 2'b01;
                        dat_next = {2{cpu_wdat_i[7:0]}};
                    end else begin
                        sel_next = 2'b11;
                        dat_next = cpu_wdat_i;
                    end
                end
            end
            CPU1: begin
                if (cyc_ack) begin
                    stb_next = 1'b0;
                    if (!we_reg) begin
                        if (byte_reg)
                            rdat_next = {8'h00, adr_reg[0] ? bus_dat[15:8] : bus_dat[7:0]};
                        else if (odd_reg)
                            rdat_next[7:0] = bus_dat[15:8];
                        else
                            rdat_next = bus_dat;
                    end
                    if (odd_reg) begin
                        state_next = CPU2;
                        adr_next   = adr_inc;
                        sel_next   = 2'b01;
                        dat_next   = {2{hi_reg}};
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        token_next = 1'b0;
                    end
                end
            end
            CPU2: begin
                // First CPU2 clock is the idle gap between the two halves of a split word
                if (!stb_reg) begin
                    stb_next = 1'b1;
                end else if (cyc_ack) begin
                    stb_next = 1'b0;
                    if (!we_reg)
                        rdat_next[15:8] = bus_dat[7:0];
                    state_next = IDLE;
                    done_next  = 1'b1;
                    token_next = 1'b0;
                end
            end
            HOLD: begin
                if (!dma_hreq_i) begin
                    state_next = IDLE;
                    token_next = cpu_mem_op_i;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign hold         = (state_reg == HOLD);
    assign dma_hlda_o   = hold;
    assign wb_ack_dma_o = wb_ack_i & hold;
    assign cpu_block_o  = cpu_mem_op_i & ~done_reg;
    assign cpu_rdat_o   = rdat_reg;

    assign wb_adr_o = hold ? dma_adr_i[19:1] : adr_reg[19:1];
    assign wb_dat_o = hold ? dma_dat_i : dat_reg;
    assign wb_sel_o = hold ? dma_sel_i : sel_reg;
    assign wb_we_o  = hold ? dma_we_i  : we_reg;
    assign wb_tga_o = hold ? dma_tga_i : tga_reg;
    assign wb_stb_o = hold ? dma_stb_i : stb_reg;
    assign wb_cyc_o = hold ? dma_stb_i : stb_reg;

    assign unused_bits = dma_adr_i[0] ^ (TMO_CYCLES != 0);

endmodule

// File: tb/tb_zet_bus_arbiter.sv
// Scoreboard bench for zet_bus_arbiter: expected bus cycles and read data are queued when a
// request is driven and checked when the bus acks / the CPU stall releases.
module tb_zet_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] cpu_adr_i;
    logic [15:0] cpu_wdat_i;
    logic [15:0] cpu_rdat_o;
    logic        cpu_byte_i, cpu_mem_op_i, cpu_m_io_i, cpu_we_i, cpu_block_o;
    logic        dma_hreq_i, dma_hlda_o;
    logic [19:0] dma_adr_i;
    logic [15:0] dma_dat_i;
    logic [1:0]  dma_sel_i;
    logic        dma_we_i, dma_stb_i, dma_tga_i;
    logic [18:0] wb_adr_o;
    logic [15:0] wb_dat_o, wb_dat_i;
    logic [1:0]  wb_sel_o;
    logic        wb_we_o, wb_tga_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_ack_dma_o, bus_err_o;

    typedef struct {
        logic [18:0] adr;
        logic [1:0]  sel;
        logic        we;
        logic        tga;
        logic [15:0] dat;
        logic [15:0] mask;
    } bus_t;

    bus_t        exp_q[$];
    logic [15:0] rd_q[$];
    bus_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;

    int          wait_states = 0;
    logic        slave_en = 1'b1;
    int          wcnt = 0;

    zet_bus_arbiter #(.TMO_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_adr_i(cpu_adr_i), .cpu_wdat_i(cpu_wdat_i), .cpu_rdat_o(cpu_rdat_o),
        .cpu_byte_i(cpu_byte_i), .cpu_mem_op_i(cpu_mem_op_i), .cpu_m_io_i(cpu_m_io_i),
        .cpu_we_i(cpu_we_i), .cpu_block_o(cpu_block_o),
        .dma_hreq_i(dma_hreq_i), .dma_hlda_o(dma_hlda_o), .dma_adr_i(dma_adr_i),
        .dma_dat_i(dma_dat_i), .dma_sel_i(dma_sel_i), .dma_we_i(dma_we_i),
        .dma_stb_i(dma_stb_i), .dma_tga_i(dma_tga_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i), .wb_ack_dma_o(wb_ack_dma_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] slave_data(input logic [18:0] a);
        if (a == 19'h00200) return 16'h1234;
        return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
    endfunction

    // Wishbone slave: combinational ack after wait_states clocks of strobe
    assign wb_ack_i = slave_en && wb_stb_o && wb_cyc_o && (wcnt >= wait_states);
    assign wb_dat_i = slave_data(wb_adr_o);
    always @(posedge clk) begin
        if (wb_stb_o && !wb_ack_i) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(negedge clk) begin
        if (rst && wb_stb_o && wb_ack_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bus_cycle: unexpected cycle adr=%h sel=%b we=%b, none required", wb_adr_o, wb_sel_o, wb_we_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (wb_adr_o !== mon_e.adr || wb_sel_o !== mon_e.sel || wb_we_o !== mon_e.we ||
                    wb_tga_o !== mon_e.tga || wb_cyc_o !== 1'b1 || (wb_dat_o & mon_e.mask) !== mon_e.dat) begin
                    n_fail++;
                    $display("FAIL bus_cycle: got adr=%h sel=%b we=%b tga=%b cyc=%b dat=%h, required adr=%h sel=%b we=%b tga=%b dat=%h mask=%h",
                             wb_adr_o, wb_sel_o, wb_we_o, wb_tga_o, wb_cyc_o, wb_dat_o,
                             mon_e.adr, mon_e.sel, mon_e.we, mon_e.tga, mon_e.dat, mon_e.mask);
                end else begin
                    $display("bus cycle adr=%h sel=%b we=%b tga=%b dat_o=%h dat_i=%h", wb_adr_o, wb_sel_o, wb_we_o, wb_tga_o, wb_dat_o, wb_dat_i);
                end
            end
        end
    end

    // Reference model: bus cycles and read result a CPU access must produce
    task automatic plan(input logic [19:0] adr, input logic we, input logic is_byte,
                        input logic mio, input logic [15:0] wdat);
        logic [19:0] a, b;
        bus_t c;
        logic [15:0] d0, d1;
        a = mio ? {4'h0, adr[15:0]} : adr;
        b = mio ? {4'h0, a[15:0] + 16'd1} : a + 20'd1;
        d0 = slave_data(a[19:1]);
        d1 = slave_data(b[19:1]);
        c.we = we; c.tga = mio; c.adr = a[19:1];
        if (is_byte) begin
            c.sel = a[0] ? 2'b10 : 2'b01;
            c.mask = we ? (a[0] ? 16'hFF00 : 16'h00FF) : 16'h0000;
            c.dat = we ? (a[0] ? {wdat[7:0], 8'h00} : {8'h00, wdat[7:0]}) : 16'h0000;
            exp_q.push_back(c);
            if (!we) rd_q.push_back({8'h00, a[0] ? d0[15:8] : d0[7:0]});
        end else if (!a[0]) begin
            c.sel = 2'b11; c.mask = we ? 16'hFFFF : 16'h0000; c.dat = we ? wdat : 16'h0000;
            exp_q.push_back(c);
            if (!we) rd_q.push_back(d0);
        end else begin
            c.sel = 2'b10; c.mask = we ? 16'hFF00 : 16'h0000; c.dat = we ? {wdat[7:0], 8'h00} : 16'h0000;
            exp_q.push_back(c);
            c.adr = b[19:1]; c.sel = 2'b01;
            c.mask = we ? 16'h00FF : 16'h0000; c.dat = we ? {8'h00, wdat[15:8]} : 16'h0000;
            exp_q.push_back(c);
            if (!we) rd_q.push_back({d1[7:0], d0[15:8]});
        end
    endtask

    // Drives one CPU access; reports latency (cycle index of first unstalled clock), read data,
    // stall one clock later, and per-cycle strobe history.
    task automatic cpu_run(input logic [19:0] adr, input logic we, input logic is_byte,
                           input logic mio, input logic [15:0] wdat, output int lat,
                           output logic [15:0] rdat, output logic blk_after, output logic [7:0] stb_hist);
        plan(adr, we, is_byte, mio, wdat);
        @(posedge clk); #1;
        cpu_adr_i = adr; cpu_we_i = we; cpu_byte_i = is_byte; cpu_m_io_i = mio; cpu_wdat_i = wdat;
        cpu_mem_op_i = 1'b1;
        lat = 0; stb_hist = '0;
        forever begin
            @(negedge clk);
            if (lat < 8) stb_hist[lat] = wb_stb_o;
            if (!cpu_block_o || lat >= 300) break;
            lat++;
        end
        rdat = cpu_rdat_o;
        @(negedge clk);
        blk_after = cpu_block_o;
        cpu_mem_op_i = 1'b0;
        $display("cpu access adr=%h we=%b byte=%b io=%b wdat=%h -> lat=%0d rdat=%h", adr, we, is_byte, mio, wdat, lat, rdat);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || dma_hlda_o !== 1'b0 || cpu_rdat_o !== 16'h0 ||
            wb_sel_o !== 2'b00 || wb_adr_o !== 19'h0 || bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: stb=%b cyc=%b hlda=%b rdat=%h sel=%b adr=%h err=%b, required all 0",
                     wb_stb_o, wb_cyc_o, dma_hlda_o, cpu_rdat_o, wb_sel_o, wb_adr_o, bus_err_o);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (wb_stb_o !== 1'b0 || cpu_block_o !== 1'b0 || dma_hlda_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: stb=%b block=%b hlda=%b, required 0 0 0", wb_stb_o, cpu_block_o, dma_hlda_o);
        end
        $display("reset checked");
    endtask

    task automatic test_word_read;
        int lat; logic [15:0] r; logic ba; logic [7:0] sh; logic [15:0] e;
        cpu_run(20'h00400, 1'b0, 1'b0, 1'b0, 16'h0, lat, r, ba, sh);
        e = rd_q.pop_front();
        n_checks++;
        if (r !== e || r !== 16'h1234) begin n_fail++; $display("FAIL word_read_data: got %h required %h", r, e); end
        n_checks++;
        if (lat !== 2 || sh[1:0] !== 2'b10 || ba !== 1'b1) begin
            n_fail++; $display("FAIL word_read_timing: lat=%0d stb=%b blk_after=%b, required 2 10 1", lat, sh[1:0], ba);
        end
    endtask

    task automatic test_split_write;
        int lat; logic [15:0] r; logic ba; logic [7:0] sh;
        cpu_run(20'h00401, 1'b1, 1'b0, 1'b0, 16'hBEEF, lat, r, ba, sh);
        n_checks++;
        if (lat !== 4 || sh[3:0] !== 4'b1010 || ba !== 1'b1) begin
            n_fail++; $display("FAIL split_write_timing: lat=%0d stb=%b blk_after=%b, required 4 1010 1", lat, sh[3:0], ba);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || wb_stb_o !== 1'b0) begin
            n_fail++; $display("FAIL split_write_cycles: pending=%0d stb=%b, required 0 0", exp_q.size(), wb_stb_o);
        end
    endtask

    task automatic test_wrap;
        int lat; logic [15:0] r; logic ba; logic [7:0] sh; logic [15:0] e;
        cpu_run(20'hFFFFF, 1'b0, 1'b0, 1'b0, 16'h0, lat, r, ba, sh);
        e = rd_q.pop_front();
        n_checks++;
        if (r !== e || lat !== 4) begin n_fail++; $display("FAIL mem_wrap_read: got %h lat=%0d required %h lat=4", r, lat, e); end
        cpu_run(20'h0FFFF, 1'b0, 1'b0, 1'b1, 16'h0, lat, r, ba, sh);
        e = rd_q.pop_front();
        n_checks++;
        if (r !== e) begin n_fail++; $display("FAIL io_wrap_read: got %h required %h", r, e); end
        cpu_run(20'h30061, 1'b1, 1'b1, 1'b1, 16'h0042, lat, r, ba, sh);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL io_byte_write_timing: lat=%0d required 2", lat); end
    endtask

    task automatic test_bytes;
        int lat; logic [15:0] r; logic ba; logic [7:0] sh; logic [15:0] e;
        for (int i = 0; i < 2; i++) begin
            cpu_run(20'h00402 + 20'(i), 1'b0, 1'b1, 1'b0, 16'h0, lat, r, ba, sh);
            e = rd_q.pop_front();
            n_checks++;
            if (r !== e || lat !== 2) begin n_fail++; $display("FAIL byte_read_%0d: got %h lat=%0d required %h lat=2", i, r, lat, e); end
        end
        cpu_run(20'h00404, 1'b1, 1'b1, 1'b0, 16'hAA77, lat, r, ba, sh);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL byte_write_timing: lat=%0d required 2", lat); end
    endtask

    task automatic test_wait_states;
        int lat; logic [15:0] r; logic ba; logic [7:0] sh; logic [15:0] e;
        wait_states = 3;
        cpu_run(20'h01000, 1'b1, 1'b0, 1'b0, 16'h5AA5, lat, r, ba, sh);
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL wait_write_lat: lat=%0d required 5", lat); end
        cpu_run(20'h01003, 1'b0, 1'b0, 1'b0, 16'h0, lat, r, ba, sh);
        e = rd_q.pop_front();
        n_checks++;
        if (lat !== 10 || r !== e) begin n_fail++; $display("FAIL wait_split_read: lat=%0d rdat=%h required 10 %h", lat, r, e); end
        wait_states = 0;
    endtask

    task automatic test_back_to_back;
        logic [15:0] e;
        int n;
        plan(20'h02000, 1'b0, 1'b0, 1'b0, 16'h0);
        plan(20'h02005, 1'b0, 1'b0, 1'b0, 16'h0);
        @(posedge clk); #1;
        cpu_adr_i = 20'h02000; cpu_we_i = 1'b0; cpu_byte_i = 1'b0; cpu_m_io_i = 1'b0; cpu_mem_op_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (cpu_block_o && n < 100);
            e = rd_q.pop_front();
            n_checks++;
            if (cpu_block_o !== 1'b0 || cpu_rdat_o !== e) begin
                n_fail++; $display("FAIL back_to_back_%0d: block=%b rdat=%h required 0 %h", k, cpu_block_o, cpu_rdat_o, e);
            end
            $display("back-to-back access %0d rdat=%h after %0d cycles", k, cpu_rdat_o, n);
            if (k == 0) cpu_adr_i = 20'h02005;
            else cpu_mem_op_i = 1'b0;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL back_to_back_cycles: pending=%0d required 0", exp_q.size()); end
    endtask

    task automatic test_dma_priority;
        bus_t c;
        logic early;
        logic seen;
        logic [15:0] e;
        int n;
        @(posedge clk); #1;
        dma_hreq_i = 1'b1;
        cpu_adr_i = 20'h00802; cpu_we_i = 1'b0; cpu_byte_i = 1'b0; cpu_m_io_i = 1'b0; cpu_mem_op_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dma_hlda_o !== 1'b1 || wb_stb_o !== 1'b0 || cpu_block_o !== 1'b1) begin
            n_fail++; $display("FAIL dma_first: hlda=%b stb=%b block=%b required 1 0 1", dma_hlda_o, wb_stb_o, cpu_block_o);
        end
        c.adr = 19'h091A2; c.sel = 2'b11; c.we = 1'b1; c.tga = 1'b0; c.dat = 16'hCAFE; c.mask = 16'hFFFF;
        exp_q.push_back(c);
        @(posedge clk); #1;
        dma_adr_i = 20'h12344; dma_dat_i = 16'hCAFE; dma_sel_i = 2'b11; dma_we_i = 1'b1; dma_tga_i = 1'b0; dma_stb_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wb_ack_dma_o !== 1'b1) begin n_fail++; $display("FAIL dma_ack: got %b required 1", wb_ack_dma_o); end
        @(posedge clk); #1;
        dma_stb_i = 1'b0; dma_we_i = 1'b0;
        plan(20'h00802, 1'b0, 1'b0, 1'b0, 16'h0);
        @(posedge clk); #1;
        dma_hreq_i = 1'b0;
        @(posedge clk); #1;
        dma_hreq_i = 1'b1;
        early = 1'b0; n = 0;
        forever begin
            @(negedge clk);
            if (!cpu_block_o || n >= 100) break;
            if (dma_hlda_o) early = 1'b1;
            n++;
        end
        cpu_mem_op_i = 1'b0;
        e = rd_q.pop_front();
        n_checks++;
        if (early !== 1'b0 || cpu_block_o !== 1'b0 || cpu_rdat_o !== e) begin
            n_fail++; $display("FAIL cpu_between_holds: early_hlda=%b block=%b rdat=%h required 0 0 %h", early, cpu_block_o, cpu_rdat_o, e);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = dma_hlda_o; end
        n_checks++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL second_hlda: got %b required 1", seen); end
        @(posedge clk); #1;
        dma_hreq_i = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dma_hlda_o !== 1'b0) begin n_fail++; $display("FAIL hlda_release: got %b required 0", dma_hlda_o); end
        $display("dma priority sequence done");
    endtask

    task automatic test_hold_off;
        logic early;
        logic [15:0] e;
        int i;
        wait_states = 2;
        plan(20'h00A07, 1'b0, 1'b0, 1'b0, 16'h0);
        @(posedge clk); #1;
        cpu_adr_i = 20'h00A07; cpu_we_i = 1'b0; cpu_byte_i = 1'b0; cpu_m_io_i = 1'b0; cpu_mem_op_i = 1'b1;
        @(posedge clk); #1;
        dma_hreq_i = 1'b1;
        early = 1'b0; i = 0;
        forever begin
            @(negedge clk);
            i++;
            if (!cpu_block_o || i >= 100) break;
            if (dma_hlda_o) early = 1'b1;
        end
        cpu_mem_op_i = 1'b0;
        e = rd_q.pop_front();
        n_checks++;
        if (early !== 1'b0 || i !== 8 || cpu_rdat_o !== e) begin
            n_fail++; $display("FAIL hold_off_split: early_hlda=%b lat=%0d rdat=%h required 0 8 %h", early, i, cpu_rdat_o, e);
        end
        @(negedge clk);
        n_checks++;
        if (dma_hlda_o !== 1'b1) begin n_fail++; $display("FAIL hold_after_split: hlda=%b required 1", dma_hlda_o); end
        @(posedge clk); #1;
        dma_hreq_i = 1'b0;
        repeat (2) @(negedge clk);
        wait_states = 0;
        $display("hold-off sequence done");
    endtask

    task automatic test_reset_mid;
        wait_states = 20;
        plan(20'h00500, 1'b0, 1'b0, 1'b0, 16'h0);
        @(posedge clk); #1;
        cpu_adr_i = 20'h00500; cpu_we_i = 1'b0; cpu_byte_i = 1'b0; cpu_m_io_i = 1'b0; cpu_mem_op_i = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wb_stb_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre: stb=%b required 1", wb_stb_o); end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_drop: stb=%b cyc=%b required 0 0", wb_stb_o, wb_cyc_o);
        end
        cpu_mem_op_i = 1'b0;
        exp_q.delete();
        rd_q.delete();
        @(negedge clk);
        rst = 1'b1;
        wait_states = 0;
        repeat (2) @(negedge clk);
        $display("mid-cycle reset done");
    endtask

    task automatic test_timeout;
`ifdef ZET_ARB_TIMEOUT_EN
        int lat, errs;
        rd_q.push_back(16'hFFFF);
        slave_en = 1'b0;
        @(posedge clk); #1;
        cpu_adr_i = 20'h00600; cpu_we_i = 1'b0; cpu_byte_i = 1'b0; cpu_m_io_i = 1'b0; cpu_mem_op_i = 1'b1;
        lat = 0; errs = 0;
        forever begin
            @(negedge clk);
            if (bus_err_o) errs++;
            if (!cpu_block_o || lat >= 100) break;
            lat++;
        end
        n_checks++;
        if (lat !== 9 || cpu_rdat_o !== rd_q.pop_front()) begin
            n_fail++; $display("FAIL timeout_read: lat=%0d rdat=%h required 9 ffff", lat, cpu_rdat_o);
        end
        @(negedge clk);
        cpu_mem_op_i = 1'b0;
        if (bus_err_o) errs++;
        n_checks++;
        if (errs !== 1) begin n_fail++; $display("FAIL timeout_err_pulse: pulses=%0d required 1", errs); end
        slave_en = 1'b1;
        repeat (2) @(negedge clk);
        $display("timeout access lat=%0d", lat);
`else
        @(negedge clk);
        n_checks++;
        if (bus_err_o !== 1'b0) begin n_fail++; $display("FAIL bus_err_tied: got %b required 0", bus_err_o); end
`endif
    endtask

    initial begin
        rst = 1'b0;
        cpu_adr_i = '0; cpu_wdat_i = '0; cpu_byte_i = 1'b0; cpu_mem_op_i = 1'b0; cpu_m_io_i = 1'b0; cpu_we_i = 1'b0;
        dma_hreq_i = 1'b0; dma_adr_i = '0; dma_dat_i = '0; dma_sel_i = '0; dma_we_i = 1'b0; dma_stb_i = 1'b0; dma_tga_i = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_word_read;
        test_split_write;
        test_wrap;
        test_bytes;
        test_wait_states;
        test_back_to_back;
        test_dma_priority;
        test_hold_off;
        test_reset_mid;
        test_timeout;
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: bus=%0d rd=%0d left, required 0 0", exp_q.size(), rd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
